// File: rtl/axis_packet_arbiter_pkg.sv
// Shared router definitions: routing header TID value and arbiter FSM states.
package axis_packet_arbiter_pkg;

   // TID value that marks the first flit of a packet (a request for the output).
   localparam int unsigned ROUTING_HEADER = 32'd10;

   // Arbiter FSM states, kept as plain constants for legacy tool compatibility.
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/axis_packet_arbiter_rr_arbiter.sv
// Combinational round-robin pick: searches upward from last_grant+1 with wrap.
module rr_arbiter #(
   parameter int INPUT_NUMBER       = 5,
   parameter int INPUT_NUMBER_WIDTH = $clog2(INPUT_NUMBER)
) (
   input  logic [INPUT_NUMBER-1:0]       i_req,
   input  logic [INPUT_NUMBER_WIDTH-1:0] i_last_grant,
   output logic [INPUT_NUMBER-1:0]       o_grant_onehot,
   output logic [INPUT_NUMBER_WIDTH-1:0] o_grant_idx,
   output logic                          o_grant_any
);

   logic [INPUT_NUMBER_WIDTH-1:0] w_cand;

   // First requester after last_grant wins; last_grant itself is checked last.
   always_comb begin
      o_grant_onehot = '0;
      o_grant_idx    = '0;
      o_grant_any    = 1'b0;
      w_cand         = '0;
      for (int k = 1; k <= INPUT_NUMBER; k++) begin
         w_cand = INPUT_NUMBER_WIDTH'((int'(i_last_grant) + k) % INPUT_NUMBER);
         if (!o_grant_any && i_req[w_cand]) begin
            o_grant_any            = 1'b1;
            o_grant_idx            = w_cand;
            o_grant_onehot[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-level AXI-Stream arbiter: locks the shared output to one input from
// its routing header until the TLAST handshake, then re-arbitrates round-robin.
module axis_packet_arbiter
   import axis_packet_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH         = 32,
   parameter int ID_WIDTH           = 4,
   parameter int INPUT_NUMBER       = 5,
   parameter int INPUT_NUMBER_WIDTH = $clog2(INPUT_NUMBER)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [INPUT_NUMBER-1:0]                in_tvalid,
   output logic [INPUT_NUMBER-1:0]                in_tready,
   input  logic [INPUT_NUMBER-1:0][DATA_WIDTH-1:0] in_tdata,
   input  logic [INPUT_NUMBER-1:0][ID_WIDTH-1:0]   in_tid,
   input  logic [INPUT_NUMBER-1:0]                in_tlast,
   output logic                                   out_tvalid,
   input  logic                                   out_tready,
   output logic [DATA_WIDTH-1:0]                  out_tdata,
   output logic [ID_WIDTH-1:0]                    out_tid,
   output logic                                   out_tlast,
   output logic [INPUT_NUMBER_WIDTH-1:0]          current_grant,
   output logic                                   grant_valid
);

   logic [0:0]                    r_state;
   logic [INPUT_NUMBER_WIDTH-1:0] r_grant;
   logic [INPUT_NUMBER-1:0]       r_grant_oh;
   logic [INPUT_NUMBER_WIDTH-1:0] r_last_grant;

   logic [INPUT_NUMBER-1:0]       w_req;
   logic [INPUT_NUMBER-1:0]       w_pick_oh;
   logic [INPUT_NUMBER_WIDTH-1:0] w_pick_idx;
   logic                          w_pick_any;
   logic                          w_locked;
   logic                          w_last_hs;

   // Only a valid header flit counts as a request for the output.
   always_comb begin
      w_req = '0;
      for (int i = 0; i < INPUT_NUMBER; i++) begin
         w_req[i] = in_tvalid[i] && (in_tid[i] == ID_WIDTH'(ROUTING_HEADER));
      end
   end

   rr_arbiter #(
      .INPUT_NUMBER       (INPUT_NUMBER),
      .INPUT_NUMBER_WIDTH (INPUT_NUMBER_WIDTH)
   ) u_rr (
      .i_req          (w_req),
      .i_last_grant   (r_last_grant),
      .o_grant_onehot (w_pick_oh),
      .o_grant_idx    (w_pick_idx),
      .o_grant_any    (w_pick_any)
   );

   // Unbuffered output mux: the owner drives out directly and sees out's ready.
   always_comb begin
      w_locked   = (r_state == ST_LOCKED);
      out_tvalid = w_locked & in_tvalid[r_grant];
      out_tdata  = in_tdata[r_grant];
      out_tid    = in_tid[r_grant];
      out_tlast  = in_tlast[r_grant];
      in_tready  = {INPUT_NUMBER{w_locked & out_tready}} & r_grant_oh;
      w_last_hs  = out_tvalid && out_tready && out_tlast;
   end

   // FSM: grant a pick only from IDLE, release after the TLAST handshake, which
   // forces one idle bubble between packets.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_grant_oh   <= INPUT_NUMBER'(1);
         r_last_grant <= INPUT_NUMBER_WIDTH'(INPUT_NUMBER - 1);
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pick_any) begin
                  r_state    <= ST_LOCKED;
                  r_grant    <= w_pick_idx;
                  r_grant_oh <= w_pick_oh;
               end
            end
            ST_LOCKED: begin
               if (w_last_hs) begin
                  r_state      <= ST_IDLE;
                  r_last_grant <= r_grant;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign current_grant = r_grant;
   assign grant_valid   = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: directed scenarios then randomized traffic,
// every cycle compared against a packet-level reference model.
module tb_axis_packet_arbiter;
   import axis_packet_arbiter_pkg::*;

   localparam int N  = 5;
   localparam int DW = 32;
   localparam int IW = 4;
   localparam int GW = $clog2(N);
   localparam logic [IW-1:0] HDR  = IW'(ROUTING_HEADER);
   localparam logic [IW-1:0] NHDR = 4'h3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         in_tvalid;
   logic [N-1:0]         in_tready;
   logic [N-1:0][DW-1:0] in_tdata;
   logic [N-1:0][IW-1:0] in_tid;
   logic [N-1:0]         in_tlast;
   logic                 out_tvalid;
   logic                 out_tready;
   logic [DW-1:0]        out_tdata;
   logic [IW-1:0]        out_tid;
   logic                 out_tlast;
   logic [GW-1:0]        current_grant;
   logic                 grant_valid;

   axis_packet_arbiter #(
      .DATA_WIDTH (DW), .ID_WIDTH (IW), .INPUT_NUMBER (N), .INPUT_NUMBER_WIDTH (GW)
   ) dut (
      .clk (clk), .rst (rst),
      .in_tvalid (in_tvalid), .in_tready (in_tready), .in_tdata (in_tdata),
      .in_tid (in_tid), .in_tlast (in_tlast),
      .out_tvalid (out_tvalid), .out_tready (out_tready), .out_tdata (out_tdata),
      .out_tid (out_tid), .out_tlast (out_tlast),
      .current_grant (current_grant), .grant_valid (grant_valid)
   );

   always #5 clk = ~clk;

   // source state: flits remaining, sequence counter, next flit is header, valid gap
   int  src_rem [N];
   int  src_seq [N];
   bit  src_hdr [N];
   bit  src_gap [N];
   // reference model: owner (-1 = none), displayed grant, last winner
   int  m_owner;
   int  m_grant;
   int  m_last;
   bit  m_known;
   int  n_tests;
   int  n_fail;
   int  dut_hs_cnt;
   logic [DW-1:0] dut_hs_data [8];
   bit  saw_tready0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         in_tvalid[i] = (src_rem[i] > 0) && !src_gap[i];
         in_tid[i]    = src_hdr[i] ? HDR : NHDR;
         in_tlast[i]  = (src_rem[i] == 1);
         in_tdata[i]  = {8'(i), 24'(src_seq[i])};
      end
   endtask

   task automatic clear_sources();
      for (int i = 0; i < N; i++) begin
         src_rem[i] = 0;
         src_hdr[i] = 1'b0;
         src_gap[i] = 1'b0;
      end
   endtask

   task automatic start_pkt(input int i, input int len);
      src_rem[i] = len;
      src_hdr[i] = 1'b1;
      src_gap[i] = 1'b0;
   endtask

   function automatic bit m_req(input int c);
      return in_tvalid[c] && (in_tid[c] == HDR);
   endfunction

   task automatic check_outputs();
      logic [N-1:0] exp_rdy;
      logic         exp_v;
      exp_v   = (m_owner >= 0) ? in_tvalid[m_owner] : 1'b0;
      exp_rdy = '0;
      if (m_owner >= 0 && out_tready) exp_rdy[m_owner] = 1'b1;
      chk("grant_valid", 64'(grant_valid), 64'(m_owner >= 0));
      chk("current_grant", 64'(current_grant), 64'(m_grant));
      chk("out_tvalid", 64'(out_tvalid), 64'(exp_v));
      chk("in_tready", 64'(in_tready), 64'(exp_rdy));
      if (m_owner >= 0) begin
         chk("out_tdata", 64'(out_tdata), 64'(in_tdata[m_owner]));
         chk("out_tid", 64'(out_tid), 64'(in_tid[m_owner]));
         chk("out_tlast", 64'(out_tlast), 64'(in_tlast[m_owner]));
      end
   endtask

   // One clock: check at negedge, advance model and sources at posedge, redrive.
   task automatic tick();
      int o;
      bit hs;
      @(negedge clk);
      if (m_known) check_outputs();
      if (out_tvalid === 1'b1 && out_tready) begin
         if (dut_hs_cnt < 8) dut_hs_data[dut_hs_cnt] = out_tdata;
         dut_hs_cnt++;
      end
      if (in_tready[0] === 1'b1) saw_tready0 = 1'b1;
      o  = m_owner;
      hs = (o >= 0) && in_tvalid[o] && out_tready;
      @(posedge clk);
      if (rst) begin
         m_owner = -1; m_grant = 0; m_last = N - 1; m_known = 1'b1;
      end else if (o < 0) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (m_req(c)) begin
               m_owner = c; m_grant = c;
               break;
            end
         end
      end else if (hs && in_tlast[o]) begin
         m_last = o; m_owner = -1;
      end
      if (hs) begin
         src_rem[o]--; src_seq[o]++; src_hdr[o] = 1'b0;
      end
      #1;
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b1; out_tready = 1'b1;
      clear_sources(); drive();
      tick(); tick();
      rst = 1'b0; drive();
   endtask

   initial begin
      n_tests = 0; n_fail = 0; m_known = 1'b0;
      m_owner = -1; m_grant = 0; m_last = N - 1;
      dut_hs_cnt = 0; saw_tready0 = 1'b0;
      for (int i = 0; i < N; i++) src_seq[i] = 0;
      rst = 1'b1; out_tready = 1'b1;
      clear_sources(); drive();
      do_reset();
      chk("reset_grant_valid", 64'(grant_valid), 64'(0));
      chk("reset_current_grant", 64'(current_grant), 64'(0));

      // Simultaneous headers on 1 and 3: 1 first, 3 after one bubble.
      start_pkt(1, 2); start_pkt(3, 2); drive();
      tick();
      chk("rr_first_grant", 64'(current_grant), 64'(1));
      tick(); tick();
      chk("bubble_grant_valid", 64'(grant_valid), 64'(0));
      chk("bubble_hold_grant", 64'(current_grant), 64'(1));
      tick();
      chk("rr_second_grant", 64'(current_grant), 64'(3));
      tick(); tick(); tick();

      // All inputs request single-flit packets continuously.
      do_reset();
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < N; i++) if (src_rem[i] == 0) start_pkt(i, 1);
         drive();
         tick();
         chk("rr_order_valid", 64'(grant_valid), 64'(1));
         chk("rr_order_grant", 64'(current_grant), 64'(p % N));
         tick();
      end

      // 4-flit packet on input 2 with output back-pressure mid-packet.
      do_reset();
      src_seq[2] = 0; start_pkt(2, 4); drive();
      tick();
      chk("bp_grant", 64'(current_grant), 64'(2));
      dut_hs_cnt = 0; saw_tready0 = 1'b0;
      start_pkt(0, 1); drive();
      tick();
      out_tready = 1'b0;
      tick(); tick(); tick();
      out_tready = 1'b1;
      tick(); tick();
      chk("bp_lock_held", 64'(grant_valid), 64'(1));
      tick();
      chk("bp_released", 64'(grant_valid), 64'(0));
      chk("bp_flit_count", 64'(dut_hs_cnt), 64'(4));
      for (int k = 0; k < 4; k++) chk("bp_flit_data", 64'(dut_hs_data[k]), 64'({8'd2, 24'(k)}));
      chk("bp_in0_never_ready", 64'(saw_tready0), 64'(0));
      tick();
      chk("bp_next_grant", 64'(current_grant), 64'(0));
      tick(); tick();

      // Non-header flit on input 4 while idle.
      do_reset();
      src_rem[4] = 1; src_hdr[4] = 1'b0; drive();
      tick(); tick(); tick();
      chk("nohdr_no_grant", 64'(grant_valid), 64'(0));
      chk("nohdr_tready", 64'(in_tready[4]), 64'(0));
      clear_sources(); drive();

      // Reset on flit 2 of a 5-flit packet from input 3.
      do_reset();
      start_pkt(3, 5); drive();
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; clear_sources(); drive();
      chk("midrst_grant_valid", 64'(grant_valid), 64'(0));
      chk("midrst_out_tvalid", 64'(out_tvalid), 64'(0));
      start_pkt(0, 1); start_pkt(3, 1); drive();
      tick();
      chk("midrst_regrant", 64'(current_grant), 64'(0));
      chk("midrst_regrant_valid", 64'(grant_valid), 64'(1));
      tick(); tick(); tick();

      // Randomized traffic with gaps, back-pressure and occasional reset.
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++) begin
            if (src_rem[i] == 0 && $urandom_range(0, 3) == 0) start_pkt(i, int'($urandom_range(1, 4)));
            src_gap[i] = ($urandom_range(0, 4) == 0);
         end
         out_tready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 149) == 0);
         drive();
         tick();
         if (rst) begin
            rst = 1'b0; clear_sources(); drive();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
